// File: rtl/hazard_pkg.sv
// Shared constants, state encoding and register-compare helper for the
// five-stage pipeline hazard unit.
package hazard_pkg;

  localparam int WB_MEM  = 1;
  localparam int WB_MULT = 3;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    DMISS    = 2'b01,
    MULTWAIT = 2'b10,
    IMISS    = 2'b11
  } state_t;

  // Register 0 is hardwired, so it never matches a producer.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Forward-source selector: compares one consumer register against the M and
// W destinations; M wins because it holds the younger result.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_reg_write_m,
  input  logic [4:0] i_write_reg_m,
  input  logic       i_reg_write_w,
  input  logic [4:0] i_write_reg_w,
  output logic [1:0] o_sel
);

  // Priority compare, M stage first
  always_comb begin
    o_sel = FWD_REG;
    if (i_reg_write_m && reg_match(i_src, i_write_reg_m)) begin
      o_sel = FWD_M;
    end else if (i_reg_write_w && reg_match(i_src, i_write_reg_w)) begin
      o_sel = FWD_W;
    end else begin
      o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stalls, flushes and forward selects for the MIPS
// datapath, plus in-flight multiply tracking and saturating stall counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hitF,
  input  logic [1:0]       branchD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             jumpd,
  input  logic             pcsrcd,
  input  logic             RegWriteE,
  input  logic             MultStartE,
  input  logic             MultDoneE,
  input  logic [3:0]       WBSrcE,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteM,
  input  logic             hitM,
  input  logic [3:0]       WBSrcM,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] mult_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     r_state;
  state_t     w_state_next;
  logic       r_mult_busy;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;
  logic [1:0] w_fwd_ad;
  logic [1:0] w_fwd_bd;
  logic       w_lwstall;
  logic       w_brstall;
  logic       w_multwait;
  logic       w_inc_lu;
  logic       w_inc_br;
  logic       w_inc_miss;
  logic       w_inc_mult;
  logic       w_unused;

  fwd_select u_fwd_ae (
    .i_src(RsE), .i_reg_write_m(RegWriteM), .i_write_reg_m(WriteRegM),
    .i_reg_write_w(RegWriteW), .i_write_reg_w(WriteRegW), .o_sel(w_fwd_ae)
  );
  fwd_select u_fwd_be (
    .i_src(RtE), .i_reg_write_m(RegWriteM), .i_write_reg_m(WriteRegM),
    .i_reg_write_w(RegWriteW), .i_write_reg_w(WriteRegW), .o_sel(w_fwd_be)
  );
  fwd_select u_fwd_ad (
    .i_src(RsD), .i_reg_write_m(RegWriteM), .i_write_reg_m(WriteRegM),
    .i_reg_write_w(RegWriteW), .i_write_reg_w(WriteRegW), .o_sel(w_fwd_ad)
  );
  fwd_select u_fwd_bd (
    .i_src(RtD), .i_reg_write_m(RegWriteM), .i_write_reg_m(WriteRegM),
    .i_reg_write_w(RegWriteW), .i_write_reg_w(WriteRegW), .o_sel(w_fwd_bd)
  );

  assign w_lwstall = WBSrcE[WB_MEM] && ((RtE == RsD) || (RtE == RtD));
  assign w_brstall = (branchD != 2'b00) &&
                     ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                      (WBSrcM[WB_MEM] && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
  assign w_multwait = WBSrcE[WB_MULT] && r_mult_busy && !MultDoneE;

  // Redirects need no action: a pending branch stall already holds F and D.
  assign w_unused = ^{jumpd, pcsrcd, r_state, WBSrcE, WBSrcM};

  // Priority-ordered hazard resolution: next state, stall/flush/forward, counter enables
  always_comb begin
    w_state_next = RUN;
    stallF       = 1'b0;
    stallD       = 1'b0;
    flushE       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    stallW       = 1'b0;
    forwardAE    = FWD_REG;
    forwardBE    = FWD_REG;
    forwardAD    = 1'b0;
    forwardBD    = 1'b0;
    w_inc_lu     = 1'b0;
    w_inc_br     = 1'b0;
    w_inc_miss   = 1'b0;
    w_inc_mult   = 1'b0;
    if (rst) begin
      w_state_next = RUN;
    end else begin
      forwardAE = w_fwd_ae;
      forwardBE = w_fwd_be;
      forwardAD = (w_fwd_ad == FWD_M);
      forwardBD = (w_fwd_bd == FWD_M);
      if (!hitM) begin
        w_state_next = DMISS;
        {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
        w_inc_miss   = 1'b1;
      end else if (w_multwait) begin
        w_state_next = MULTWAIT;
        {stallF, stallD, stallE} = 3'b111;
        w_inc_mult   = 1'b1;
      end else if (!hitF) begin
        w_state_next = IMISS;
        {stallF, stallD, flushE} = 3'b111;
        w_inc_miss   = 1'b1;
      end else if (w_lwstall || w_brstall) begin
        w_state_next = RUN;
        {stallF, stallD, flushE} = 3'b111;
        w_inc_lu     = w_lwstall;
        w_inc_br     = w_brstall;
      end else begin
        w_state_next = RUN;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In-flight multiply tracker; a start in the retire cycle keeps it busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mult_busy <= 1'b0;
    end else if (MultStartE) begin
      r_mult_busy <= 1'b1;
    end else if (MultDoneE) begin
      r_mult_busy <= 1'b0;
    end else begin
      r_mult_busy <= r_mult_busy;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      load_use_cnt <= '0;
      branch_cnt   <= '0;
      miss_cnt     <= '0;
      mult_cnt     <= '0;
    end else begin
      if (w_inc_lu && (load_use_cnt != CNT_MAX)) load_use_cnt <= load_use_cnt + CNT_ONE;
      if (w_inc_br && (branch_cnt != CNT_MAX))   branch_cnt   <= branch_cnt + CNT_ONE;
      if (w_inc_miss && (miss_cnt != CNT_MAX))   miss_cnt     <= miss_cnt + CNT_ONE;
      if (w_inc_mult && (mult_cnt != CNT_MAX))   mult_cnt     <= mult_cnt + CNT_ONE;
    end
  end

endmodule
